multicycle_control_fsm: RTL and testbench

//  Main control unit of the multi-cycle RV32I core; sibling of the datapath, which it drives.

---
 rtl/multicycle_control_fsm.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: a Moore sequencer for fetch/decode/execute/
// memory/writeback, plus the ALU decoder and the beq/bne branch resolver.
module multicycle_control_fsm #(
  parameter logic SUPPORT_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       zero,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic       RegWrite
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_JALRLINK = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RALU  = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Unsupported funct3 codes (shifts, sltu) quietly fall back to ADD.
  function automatic logic [2:0] alu_decode(input logic [2:0] fn3, input logic sub_en);
    case (fn3)
      3'b000:  return sub_en ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b010:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  logic [3:0] state_q, state_d;
  logic       pc_w, adr_w, mem_w, ir_w, reg_w;
  logic [1:0] res_w, srca_w, srcb_w;
  logic [2:0] alu_w, imm_w;
  logic       unused_f7;

  assign unused_f7 = ^{f7[6], f7[4:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    pc_w    = 1'b0;
    adr_w   = 1'b0;
    mem_w   = 1'b0;
    ir_w    = 1'b0;
    reg_w   = 1'b0;
    res_w   = 2'b00;
    srca_w  = 2'b00;
    srcb_w  = 2'b00;
    alu_w   = ALU_ADD;
    imm_w   = IMM_I;
    case (state_q)
      S_FETCH: begin
        ir_w = 1'b1; srcb_w = 2'b10; res_w = 2'b10; pc_w = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        srca_w = 2'b01; srcb_w = 2'b01;
        imm_w  = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RALU:           state_d = S_EXECR;
          OP_IALU:           state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        srca_w = 2'b10; srcb_w = 2'b01;
        imm_w   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD:  begin adr_w = 1'b1; state_d = S_MEMWB; end
      S_MEMWB:    begin res_w = 2'b01; reg_w = 1'b1; end
      S_MEMWRITE: begin adr_w = 1'b1; mem_w = 1'b1; end
      S_EXECR: begin
        srca_w = 2'b10; alu_w = alu_decode(f3, f7[5]);
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        srca_w = 2'b10; srcb_w = 2'b01; alu_w = alu_decode(f3, 1'b0);
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BRANCH: begin
        srca_w = 2'b10; alu_w = ALU_SUB;
        pc_w = ((f3 == 3'b000) & zero) | (SUPPORT_BNE & (f3 == 3'b001) & ~zero);
      end
      S_JAL: begin
        srca_w = 2'b01; srcb_w = 2'b10; pc_w = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        srca_w = 2'b10; srcb_w = 2'b01; res_w = 2'b10; pc_w = 1'b1;
        state_d = S_JALRLINK;
      end
      // Link value OldPC+4 is computed after the jump so ALUOut holds it for ALUWB.
      S_JALRLINK: begin
        srca_w = 2'b01; srcb_w = 2'b10;
        state_d = S_ALUWB;
      end
      S_LUI:   begin imm_w = IMM_U; res_w = 2'b11; reg_w = 1'b1; end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every output, so an aborted instruction can never write anything.
  assign PCWrite    = pc_w  & ~rst;
  assign AdrSrc     = adr_w & ~rst;
  assign MemWrite   = mem_w & ~rst;
  assign IRWrite    = ir_w  & ~rst;
  assign RegWrite   = reg_w & ~rst;
  assign ResultSrc  = rst ? 2'b00 : res_w;
  assign ALUControl = rst ? 3'b000 : alu_w;
  assign ALUSrcA    = rst ? 2'b00 : srca_w;
  assign ALUSrcB    = rst ? 2'b00 : srcb_w;
  assign ImmSrc     = rst ? 3'b000 : imm_w;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed scenarios plus a random instruction
// stream, each compared cycle by cycle against a per-instruction expected-output sequence.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       zero = 1'b0;
  logic [6:0] opcode = 7'h00;
  logic [2:0] f3 = 3'd0;
  logic [6:0] f7 = 7'd0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] outv;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .zero(zero), .opcode(opcode), .f3(f3), .f7(f7),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  assign outv = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                 ALUSrcA, ALUSrcB, ImmSrc, RegWrite};

  function automatic logic [16:0] mk(input logic pc, input logic adr, input logic mw,
                                     input logic ir, input logic [1:0] rs, input logic [2:0] alu,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] imm, input logic rw);
    return {pc, adr, mw, ir, rs, alu, a, b, imm, rw};
  endfunction

  function automatic logic [2:0] ref_alu(input logic [2:0] fn3, input logic [6:0] fn7,
                                         input logic rtype);
    case (fn3)
      3'b000:  return (rtype && fn7[5]) ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b100:  return 3'b100;
      3'b010:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // Expected output of every cycle of one instruction, starting at its fetch cycle.
  task automatic model_instr(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                             input logic z);
    logic [16:0] aluwb;
    logic taken;
    aluwb = mk(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 1);
    exp_q = {};
    exp_q.push_back(mk(1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 3'b000, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01,
                       (op == 7'b1101111) ? 3'b011 : 3'b010, 0));
    case (op)
      7'b0000011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 3'b000, 0));
        exp_q.push_back(mk(0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 2'b00, 3'b000, 1));
      end
      7'b0100011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 3'b001, 0));
        exp_q.push_back(mk(0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0));
      end
      7'b0110011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 2'b00, ref_alu(fn3, fn7, 1'b1), 2'b10, 2'b00, 3'b000, 0));
        exp_q.push_back(aluwb);
      end
      7'b0010011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 2'b00, ref_alu(fn3, fn7, 1'b0), 2'b10, 2'b01, 3'b000, 0));
        exp_q.push_back(aluwb);
      end
      7'b1100011: begin
        taken = (fn3 == 3'b000) ? z : (fn3 == 3'b001) ? !z : 1'b0;
        exp_q.push_back(mk(taken, 0, 0, 0, 2'b00, 3'b001, 2'b10, 2'b00, 3'b000, 0));
      end
      7'b1101111: begin
        exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 3'b000, 0));
        exp_q.push_back(aluwb);
      end
      7'b1100111: begin
        exp_q.push_back(mk(1, 0, 0, 0, 2'b10, 3'b000, 2'b10, 2'b01, 3'b000, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 3'b000, 0));
        exp_q.push_back(aluwb);
      end
      7'b0110111:
        exp_q.push_back(mk(0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 2'b00, 3'b100, 1));
      default: ;
    endcase
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outv !== 17'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d got %h want %h", i, outv, 17'd0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    opcode = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; zero = 1'b0;
    model_instr(opcode, f3, f7, zero);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      checks++;
      if (outv !== exp_q[k]) begin
        errors++;
        $display("FAIL rtype_sub cyc%0d got %h want %h", k, outv, exp_q[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    opcode = 7'b0000011; f3 = 3'b010; f7 = 7'd0;
    model_instr(opcode, f3, f7, zero);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      checks++;
      if (outv !== exp_q[k] || MemWrite !== 1'b0) begin
        errors++;
        $display("FAIL load_walk cyc%0d got %h want %h", k, outv, exp_q[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    for (int t = 0; t < 4; t++) begin
      opcode = 7'b1100011; f3 = (t < 2) ? 3'b000 : 3'b001; zero = t[0]; f7 = 7'd0;
      model_instr(opcode, f3, f7, zero);
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clk);
        checks++;
        if (outv !== exp_q[k]) begin
          errors++;
          $display("FAIL branch f3=%0d zero=%0d cyc%0d got %h want %h",
                   f3, zero, k, outv, exp_q[k]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jalr();
    opcode = 7'b1100111; f3 = 3'b000; f7 = 7'd0;
    model_instr(opcode, f3, f7, zero);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      checks++;
      if (outv !== exp_q[k]) begin
        errors++;
        $display("FAIL jalr_walk cyc%0d got %h want %h", k, outv, exp_q[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b1111111; f3 = 3'b000; f7 = 7'd0;
    model_instr(opcode, f3, f7, zero);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      checks++;
      if (outv !== exp_q[k] || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
        errors++;
        $display("FAIL illegal_nop cyc%0d got %h want %h", k, outv, exp_q[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midinstr();
    opcode = 7'b0100011; f3 = 3'b010; f7 = 7'd0;
    model_instr(opcode, f3, f7, zero);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (outv !== exp_q[k]) begin
        errors++;
        $display("FAIL store_walk cyc%0d got %h want %h", k, outv, exp_q[k]);
      end
      if (k < 3) begin @(posedge clk); #1; end
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || outv !== 17'd0) begin
      errors++;
      $display("FAIL reset_abort_immediate got %h want %h", outv, 17'd0);
    end
    @(posedge clk); #1;
    checks++;
    if (outv !== 17'd0) begin
      errors++;
      $display("FAIL reset_abort_held got %h want %h", outv, 17'd0);
    end
    opcode = 7'b1111111;
    rst = 1'b0;
    model_instr(opcode, f3, f7, zero);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      checks++;
      if (outv !== exp_q[k]) begin
        errors++;
        $display("FAIL reset_restart cyc%0d got %h want %h", k, outv, exp_q[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[8];
    int sel;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    for (int n = 0; n < 200; n++) begin
      sel    = int'($urandom_range(0, 8));
      opcode = (sel == 8) ? 7'($urandom) : ops[sel];
      f3     = 3'($urandom);
      f7     = 7'($urandom);
      zero   = 1'($urandom);
      model_instr(opcode, f3, f7, zero);
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clk);
        checks++;
        if (outv !== exp_q[k]) begin
          errors++;
          $display("FAIL random op=%b f3=%b f7=%b z=%0d cyc%0d got %h want %h",
                   opcode, f3, f7, zero, k, outv, exp_q[k]);
        end
        checks++;
        if ($countones({MemWrite, RegWrite, IRWrite}) > 1) begin
          errors++;
          $display("FAIL write_exclusive got %b want at most one high",
                   {MemWrite, RegWrite, IRWrite});
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_branch();
    test_jalr();
    test_illegal();
    test_reset_midinstr();
    test_random();
    @(negedge clk);
    checks++;
    if (outv !== mk(1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 3'b000, 0)) begin
      errors++;
      $display("FAIL final_fetch got %h want %h", outv,
               mk(1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 3'b000, 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
